wide_addsub_seq: RTL and testbench
==================================

// Module: wide_addsub_seq
// PURPOSE
//  Multi-cycle controller that drives one external 16-bit adder slice
//  (adder16-class: a, b, c_in -> sum, c_out) to perform WORDS*W-bit add/sub.
//  It latches wide operands, steps word by word LSW-first, and chains the
//  carry through a register. It returns the wide result with a start/busy/done
//  handshake. It sits between the operand source and the shared adder slice.
// PARAMETERS
//  W      16  width of the adder slice and of one word
//  WORDS  4   number of words per operation (operand width = W*WORDS)
// PORTS
//  clk       in   1        rising-edge clock
//  rst_n     in   1        asynchronous, active-low reset
//  start     in   1        request; sampled only in IDLE or DONE
//  sub       in   1        0: a+b, 1: a-b; latched with start
//  a         in   W*WORDS  operand A; latched with start
//  b         in   W*WORDS  operand B; latched with start
//  add_a     out  W        to slice: current word of A
//  add_b     out  W        to slice: current word of B (~B word when sub)
//  add_cin   out  1        to slice: carry-in
//  add_sum   in   W        from slice: sum (combinational)
//  add_cout  in   1        from slice: carry-out (combinational)
//  busy      out  1        high while in RUN
//  done      out  1        one-cycle pulse; result valid
//  result    out  W*WORDS  wide result; held until next accepted start
//  c_out     out  1        final carry (sub: 1 = no borrow)
//  ovf       out  1        signed overflow (only with ADDSUB_OVF_EN)
// BEHAVIOUR
//  - The design has one clock domain (clk). rst_n is asynchronous and
//    active-low. Asserting rst_n at any time forces IDLE, idx=0, carry=0,
//    busy=0, done=0, result=0, c_out=0, ovf=0. An operation in flight is
//    abandoned and done is not pulsed for it.
//  - FSM states: IDLE, RUN, DONE.
//    - IDLE -> RUN on start. The edge that samples start also latches a, b
//      and sub, and sets idx=0.
//    - RUN: on each edge, result word[idx] <= add_sum and carry <= add_cout.
//      idx increments. When idx==WORDS-1, the FSM moves to DONE and c_out <=
//      add_cout.
//    - DONE: done=1 for exactly one cycle, then IDLE. A start sampled in DONE
//      goes directly to RUN, giving back-to-back operation with no idle
//      cycle.
//  - Latency: done is high in the cycle following the WORDS-th edge after
//    the start-sampling edge. Throughput is one operation per WORDS+1
//    cycles.
//  - Slice drive (combinational from registers):
//    - add_a = A_reg word[idx].
//    - add_b = B_reg word[idx] ^ {W{sub_reg}}.
//    - add_cin = (idx==0) ? sub_reg : carry.
//    - Outside RUN: add_a = 0, add_b = 0, add_cin = 0.
//  - A start while busy is ignored; latched operands are unaffected.
//    Changing a, b or sub during RUN has no effect.
//  - Arithmetic is modulo 2^(W*WORDS). result and c_out hold their last
//    values in IDLE. Any bits of result not yet written keep their previous
//    values until that word is captured.
//  - idx width is clog2(WORDS), minimum 1. WORDS=1 is legal and gives a
//    single RUN cycle.
// CONFIGURATION
//  Macro ADDSUB_OVF_EN:
//  - Defined: port ovf is present. On the final RUN edge,
//    ovf <= (A_msb == Beff_msb) && (add_sum[W-1] != A_msb), where
//    Beff = B ^ {sub}. ovf holds until the next final RUN edge and is reset
//    to 0.
//  - Undefined: port ovf and its logic are absent. All other behaviour is
//    identical.
// TESTING  (W=16, WORDS=4)
//  1. rst_n=0 with start=1 -> busy=0, done=0, result=0, c_out=0; no slice
//     activity.
//  2. a=0x0000_0000_0000_FFFF, b=1, sub=0, start one cycle -> busy for 4
//     cycles; done in the cycle after the 4th edge; result=0x0000_0000_
//     0001_0000; c_out=0.
//  3. a=0xFFFF_FFFF_FFFF_FFFF, b=1, add -> result=0, c_out=1, carry
//     propagating through all 4 words. Assert start in the DONE cycle with
//     a=b=2 -> next done 5 cycles after the first, result=4.
//  4. a=5, b=7, sub=1 -> result=0xFFFF_FFFF_FFFF_FFFE, c_out=0, ovf=0.
//     Repeat with a=7, b=5 -> result=2, c_out=1.
//  5. ADDSUB_OVF_EN: a=0x7FFF_FFFF_FFFF_FFFF, b=1, add -> result=0x8000_
//     0000_0000_0000, ovf=1. a=0x8000_0000_0000_0000, b=1, sub -> ovf=1.
//  6. start during RUN with new operands -> ignored; the original result is
//     delivered. rst_n pulsed low during the 2nd RUN cycle -> busy=0,
//     result=0, no done pulse. The next start completes normally.

Source files
------------

// File: rtl/wide_addsub_seq.sv
// Multi-cycle WORDS*W-bit adder/subtractor that time-shares one external W-bit
// adder slice, LSW first. Optional signed-overflow output under ADDSUB_OVF_EN.
module wide_addsub_seq #(
  parameter int W     = 16,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic [W*WORDS-1:0]   a,
  input  logic [W*WORDS-1:0]   b,
  output logic [W-1:0]         add_a,
  output logic [W-1:0]         add_b,
  output logic                 add_cin,
  input  logic [W-1:0]         add_sum,
  input  logic                 add_cout,
  output logic                 busy,
  output logic                 done,
  output logic [W*WORDS-1:0]   result,
  output logic                 c_out,
`ifdef ADDSUB_OVF_EN
  output logic                 ovf,
`endif
  output logic [1:0]           dbg_state
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            idx_q;
  logic [WORDS-1:0][W-1:0]  a_q, b_q, result_q;
  logic                     sub_q;
  logic                     carry_q;
  logic                     c_out_q;
  logic                     last_word;
  logic                     accept;

  // Handshake: start is a request accepted whenever busy is low (IDLE or DONE);
  // there is no backpressure, a start seen while busy is simply dropped. done
  // pulses for one cycle and result/c_out stay valid until the next accept.
  assign accept    = start && (state_q != S_RUN);
  assign last_word = (idx_q == IW'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_word) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == S_RUN);
    done    = (state_q == S_DONE);
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == S_RUN) begin
      add_a   = a_q[idx_q];
      add_b   = b_q[idx_q] ^ {W{sub_q}};
      add_cin = (idx_q == '0) ? sub_q : carry_q;
    end
  end

  // Operand latch, word sequencing and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      c_out_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sub_q <= sub;
      idx_q <= '0;
    end else if (state_q == S_RUN) begin
      result_q[idx_q] <= add_sum;
      carry_q         <= add_cout;
      idx_q           <= last_word ? '0 : idx_q + IW'(1);
      if (last_word) begin
        c_out_q <= add_cout;
      end
    end
  end

`ifdef ADDSUB_OVF_EN
  logic ovf_q;
  logic a_msb;
  logic beff_msb;

  assign a_msb    = a_q[WORDS-1][W-1];
  assign beff_msb = b_q[WORDS-1][W-1] ^ sub_q;

  // Same-sign operands producing a result of the other sign overflowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == S_RUN && last_word) begin
      ovf_q <= (a_msb == beff_msb) && (add_sum[W-1] != a_msb);
    end
  end

  assign ovf = ovf_q;
`endif

  assign result    = result_q;
  assign c_out     = c_out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wide_addsub_seq.sv
// Self-checking bench for wide_addsub_seq (W=16, WORDS=4) with a behavioural
// 16-bit slice and a plain-arithmetic reference model.
module tb_wide_addsub_seq;

  localparam int W     = 16;
  localparam int WORDS = 4;
  localparam int N     = W * WORDS;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          sub;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic [W-1:0]  add_a;
  logic [W-1:0]  add_b;
  logic          add_cin;
  logic [W-1:0]  add_sum;
  logic          add_cout;
  logic          busy;
  logic          done;
  logic [N-1:0]  result;
  logic          c_out;
  logic          ovf;
  logic [1:0]    dbg_state;

  int            n_tests;
  int            n_fail;
  logic [N+1:0]  exp_q[$];
  logic [N-1:0]  cur_a;
  logic [N-1:0]  cur_b;
  logic          cur_sub;

`ifndef ADDSUB_OVF_EN
  assign ovf = 1'b0;
`endif

  wide_addsub_seq #(.W(W), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .c_out     (c_out),
`ifdef ADDSUB_OVF_EN
    .ovf       (ovf),
`endif
    .dbg_state (dbg_state)
  );

  // External adder slice.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: {ovf, c_out, result} from the arithmetic meaning.
  function automatic logic [N+1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic s);
    logic [N:0]   full;
    logic [N-1:0] r;
    logic         co;
    logic         ov;
    if (s) begin
      r  = x - y;
      co = (x >= y);
      ov = (x[N-1] != y[N-1]) && (r[N-1] != x[N-1]);
    end else begin
      full = {1'b0, x} + {1'b0, y};
      r    = full[N-1:0];
      co   = full[N];
      ov   = (x[N-1] == y[N-1]) && (r[N-1] != x[N-1]);
    end
    return {ov, co, r};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: present an operation with start high; call just after a negedge.
  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    a       = x;
    b       = y;
    sub     = s;
    start   = 1'b1;
    cur_a   = x;
    cur_b   = y;
    cur_sub = s;
    exp_q.push_back(model(x, y, s));
  endtask

  // Waits for done, checking latency, busy length, first slice word and result.
  task automatic await_done(input string tag, input bit intrude);
    int           n;
    int           busy_n;
    bit           seen;
    logic [N+1:0] e;
    busy_n = 0;
    seen   = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        check({tag, "_cin0"}, 64'(add_cin), 64'(cur_sub));
        check({tag, "_slice_a0"}, 64'(add_a), 64'(cur_a[W-1:0]));
        check({tag, "_slice_b0"}, 64'(add_b), 64'(cur_b[W-1:0] ^ {W{cur_sub}}));
      end
      if (intrude && n == 2) begin
        start = 1'b1;
        a     = {$urandom, $urandom};
        b     = {$urandom, $urandom};
        sub   = ~cur_sub;
      end
      if (intrude && n == 3) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (!seen) return;
    check({tag, "_latency"}, 64'(n), 64'(WORDS + 1));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(WORDS));
    check({tag, "_exp_avail"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check({tag, "_result"}, result, e[N-1:0]);
    check({tag, "_c_out"}, 64'(c_out), 64'(e[N]));
`ifdef ADDSUB_OVF_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(e[N+1]));
`endif
  endtask

  initial begin
    int done_cnt;
    logic [N-1:0] held;
    n_tests = 0;
    n_fail  = 0;

    // 1. Reset with start asserted
    rst_n = 1'b0;
    start = 1'b1;
    sub   = 1'b1;
    a     = 64'h1234_5678_9ABC_DEF0;
    b     = 64'h0FED_CBA9_8765_4321;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_c_out", 64'(c_out), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_slice", {29'd0, add_cin, add_a, add_b}, 64'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_slice", {29'd0, add_cin, add_a, add_b}, 64'd0);

    // 2. Carry out of word 0 into word 1
    issue(64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
    await_done("carry_w0", 1'b0);

    // 3. Full-width carry ripple, then back-to-back from the DONE cycle
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    await_done("ripple", 1'b0);
    issue(64'd2, 64'd2, 1'b0);
    await_done("b2b", 1'b0);

    // 4. Subtraction with and without borrow, then result hold in IDLE
    issue(64'd5, 64'd7, 1'b1);
    await_done("sub_borrow", 1'b0);
    issue(64'd7, 64'd5, 1'b1);
    await_done("sub_noborrow", 1'b0);
    held = result;
    repeat (3) @(negedge clk);
    check("hold_result", result, 64'd2);
    check("hold_unchanged", result, held);

    // 5. Signed overflow cases
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    await_done("ovf_add", 1'b0);
    issue(64'h8000_0000_0000_0000, 64'd1, 1'b1);
    await_done("ovf_sub", 1'b0);

    // 6a. Start during RUN is ignored
    issue(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0);
    await_done("intrude", 1'b1);
    @(negedge clk);
    check("intrude_no_rerun", 64'(busy), 64'd0);

    // 6b. Reset in the 2nd RUN cycle abandons the operation
    issue(64'hDEAD_BEEF_CAFE_F00D, 64'h0BAD_F00D_1234_5678, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_c_out", 64'(c_out), 64'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    issue(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0);
    await_done("post_abort", 1'b0);

    // Randomized operations with random idle gaps (gap 0 = back-to-back)
    for (int i = 0; i < 24; i++) begin
      logic [N-1:0] x;
      logic [N-1:0] y;
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) y = x;
      if ($urandom_range(0, 7) == 0) x = '1;
      issue(x, y, 1'($urandom_range(0, 1)));
      await_done($sformatf("rand%0d", i), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
